// File: rtl/fb_ddr_sched_if.sv
// Burst request/handshake bundle between the frame-buffer scheduler and mig_ctrl.
// The scheduler uses the master modport and mig_ctrl uses the slave modport.
interface fb_ddr_sched_if #(
    parameter int ADDR_W = 28
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [15:0]       wr_length;
    logic              wr_busy;
    logic              wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [15:0]       rd_length;
    logic              rd_busy;
    logic              rd_done;

    modport master (
        output wr_req, wr_req_addr, wr_length,
        output rd_req, rd_req_addr, rd_length,
        input  wr_busy, wr_done, rd_busy, rd_done
    );

    modport slave (
        input  wr_req, wr_req_addr, wr_length,
        input  rd_req, rd_req_addr, rd_length,
        output wr_busy, wr_done, rd_busy, rd_done
    );
endinterface

// File: rtl/fb_ddr_sched.sv
// Frame-buffer scheduler: turns FIFO levels into round-robin DDR3 burst requests
// and rotates 3..4 frame buffers so the writer never lands on the buffer being read.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no burst outstanding; arbitrate between eligible paths
// S_WR_REQ  | wr_req held with address/length until mig accepts (wr_busy)
// S_WR_WAIT | write burst accepted; waiting for wr_done
// S_RD_REQ  | rd_req held with address/length until mig accepts (rd_busy)
// S_RD_WAIT | read burst accepted; waiting for rd_done
module fb_ddr_sched #(
    parameter int ADDR_W      = 28,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_STEP   = 8,
    parameter int BURST_LEN   = 64,
    parameter int FRAME_WORDS = 230400,
    parameter int NUM_BUF     = 3,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_frame_start,
    input  logic                rd_frame_start,
    input  logic [CNT_W-1:0]    wr_fifo_cnt,
    input  logic [CNT_W-1:0]    rd_fifo_space,
    fb_ddr_sched_if.master      mig,
    output logic [1:0]          w_idx,
    output logic [1:0]          r_idx,
    output logic                frame_valid,
    output logic [15:0]         drop_cnt
);

    localparam int BURSTS = FRAME_WORDS / BURST_LEN;
    localparam int BCNT_W = $clog2(BURSTS + 1);

    localparam logic [ADDR_W-1:0] BASE         = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(longint'(FRAME_WORDS) * longint'(ADDR_STEP));
    localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(longint'(BURST_LEN) * longint'(ADDR_STEP));
    localparam logic [15:0]       LEN          = 16'(BURST_LEN);
    localparam logic [CNT_W-1:0]  LEVEL_MIN    = CNT_W'(BURST_LEN);
    localparam logic [BCNT_W-1:0] LAST_BURST   = BCNT_W'(BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_WAIT
    } state_t;

    state_t state, state_nxt;

    logic              last_wr;
    logic              wr_act;
    logic              wr_abort_pend;
    logic [BCNT_W-1:0] wr_bcnt;
    logic              rd_act;
    logic              rd_pend;
    logic [BCNT_W-1:0] rd_bcnt;
    logic [1:0]        latest;
    logic              fresh;

    logic              wr_elig, rd_elig;
    logic              wr_grant, rd_grant;
    logic              wr_in_burst, rd_in_burst;
    logic              wr_fin, rd_fin;
    logic              wr_abort_now;
    logic              publish;
    logic              rd_sw;
    logic [1:0]        r_idx_nxt;
    logic [1:0]        cand1, cand2, w_idx_pub;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    function automatic logic [ADDR_W-1:0] buf_base(input logic [1:0] idx);
        logic [ADDR_W-1:0] k;
        k      = '0;
        k[1:0] = idx;
        return BASE + k * FRAME_STRIDE;
    endfunction

    function automatic logic [1:0] wrap_idx(input logic [2:0] s);
        return (s >= 3'(NUM_BUF)) ? 2'(s - 3'(NUM_BUF)) : s[1:0];
    endfunction

    // Arbitration and frame-level events
    always_comb begin
        wr_elig      = wr_act && (wr_fifo_cnt >= LEVEL_MIN);
        rd_elig      = rd_act && (rd_fifo_space >= LEVEL_MIN);
        wr_grant     = (state == S_IDLE) && wr_elig && (!rd_elig || !last_wr);
        rd_grant     = (state == S_IDLE) && rd_elig && !wr_grant;
        wr_in_burst  = (state == S_WR_REQ) || (state == S_WR_WAIT);
        rd_in_burst  = (state == S_RD_REQ) || (state == S_RD_WAIT);
        wr_fin       = (state == S_WR_WAIT) && mig.wr_done;
        rd_fin       = (state == S_RD_WAIT) && mig.rd_done;
        wr_abort_now = wr_fin && (wr_abort_pend || wr_frame_start);
        publish      = wr_fin && !wr_abort_now && (wr_bcnt == LAST_BURST);
        rd_sw        = (rd_pend || rd_frame_start) && !rd_in_burst;
    end

    // A switch coinciding with a publish hands the reader the brand-new frame;
    // before any frame exists the reader is pointed at buffer 0.
    always_comb begin
        r_idx_nxt = r_idx;
        if (rd_sw) begin
            if (publish)
                r_idx_nxt = w_idx;
            else if (frame_valid)
                r_idx_nxt = latest;
            else
                r_idx_nxt = 2'd0;
        end
        cand1     = wrap_idx({1'b0, w_idx} + 3'd1);
        cand2     = wrap_idx({1'b0, w_idx} + 3'd2);
        w_idx_pub = ((cand1 != r_idx) && (cand1 != r_idx_nxt)) ? cand1 : cand2;
        wr_addr   = buf_base(w_idx) + ADDR_W'(wr_bcnt) * BURST_STRIDE;
        rd_addr   = buf_base(r_idx) + ADDR_W'(rd_bcnt) * BURST_STRIDE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wr_grant)
                    state_nxt = S_WR_REQ;
                else if (rd_grant)
                    state_nxt = S_RD_REQ;
            end
            S_WR_REQ:  if (mig.wr_busy) state_nxt = S_WR_WAIT;
            S_WR_WAIT: if (mig.wr_done) state_nxt = S_IDLE;
            S_RD_REQ:  if (mig.rd_busy) state_nxt = S_RD_WAIT;
            S_RD_WAIT: if (mig.rd_done) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mig.wr_req      = (state == S_WR_REQ);
        mig.rd_req      = (state == S_RD_REQ);
        mig.wr_req_addr = mig.wr_req ? wr_addr : '0;
        mig.rd_req_addr = mig.rd_req ? rd_addr : '0;
        mig.wr_length   = mig.wr_req ? LEN : 16'd0;
        mig.rd_length   = mig.rd_req ? LEN : 16'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_wr       <= 1'b0;
            wr_act        <= 1'b0;
            wr_abort_pend <= 1'b0;
            wr_bcnt       <= '0;
            rd_act        <= 1'b0;
            rd_pend       <= 1'b0;
            rd_bcnt       <= '0;
            latest        <= 2'd0;
            fresh         <= 1'b0;
            w_idx         <= 2'd0;
            r_idx         <= 2'(NUM_BUF - 1);
            frame_valid   <= 1'b0;
            drop_cnt      <= 16'd0;
        end else begin
            if (wr_grant)
                last_wr <= 1'b1;
            else if (rd_grant)
                last_wr <= 1'b0;

            // An abort arriving mid-burst is deferred so the address stays stable
            if (wr_fin) begin
                if (wr_abort_now) begin
                    wr_bcnt       <= '0;
                    wr_abort_pend <= 1'b0;
                end else if (publish) begin
                    wr_bcnt     <= '0;
                    wr_act      <= 1'b0;
                    latest      <= w_idx;
                    frame_valid <= 1'b1;
                    w_idx       <= w_idx_pub;
                    if (fresh && (drop_cnt != 16'hFFFF))
                        drop_cnt <= drop_cnt + 16'd1;
                end else begin
                    wr_bcnt <= wr_bcnt + BCNT_W'(1);
                end
            end else if (wr_frame_start) begin
                if (wr_in_burst) begin
                    wr_abort_pend <= 1'b1;
                end else begin
                    wr_act  <= 1'b1;
                    wr_bcnt <= '0;
                end
            end

            if (rd_sw && (frame_valid || publish))
                fresh <= 1'b0;
            else if (publish)
                fresh <= 1'b1;

            r_idx <= r_idx_nxt;

            if (rd_sw) begin
                rd_bcnt <= '0;
                rd_act  <= 1'b1;
                rd_pend <= 1'b0;
            end else begin
                if (rd_frame_start)
                    rd_pend <= 1'b1;
                if (rd_fin) begin
                    rd_bcnt <= rd_bcnt + BCNT_W'(1);
                    if (rd_bcnt == LAST_BURST)
                        rd_act <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_ddr_sched.sv
// Directed bench for fb_ddr_sched: eligibility vector table plus multi-frame
// sequences against a small mig_ctrl responder model (4 bursts per frame).
module tb_fb_ddr_sched;

    localparam int ADDR_W = 28;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_fs_main = 1'b0, wr_fs_resp = 1'b0;
    logic        rd_fs_main = 1'b0, rd_fs_resp = 1'b0;
    logic        wr_frame_start, rd_frame_start;
    logic [15:0] wr_fifo_cnt, rd_fifo_space;
    logic [1:0]  w_idx, r_idx;
    logic        frame_valid;
    logic [15:0] drop_cnt;

    fb_ddr_sched_if #(.ADDR_W(ADDR_W)) bus ();

    assign wr_frame_start = wr_fs_main | wr_fs_resp;
    assign rd_frame_start = rd_fs_main | rd_fs_resp;

    fb_ddr_sched #(
        .ADDR_W(ADDR_W), .BASE_ADDR(0), .ADDR_STEP(8), .BURST_LEN(64),
        .FRAME_WORDS(256), .NUM_BUF(3), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_space(rd_fifo_space),
        .mig(bus),
        .w_idx(w_idx), .r_idx(r_idx),
        .frame_valid(frame_valid), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // mig_ctrl responder: accepts one request, busy one cycle, done two cycles later
    logic              resp_en = 1'b0;
    int                wr_seen = 0;
    int                abort_at = -1;
    int                swap_at = -1;
    int                len_err = 0;
    int                log_n = 0;
    bit                log_wr [128];
    logic [ADDR_W-1:0] log_addr [128];

    initial begin
        bit                is_wr;
        logic [ADDR_W-1:0] a;
        logic [15:0]       len;
        bus.wr_busy = 1'b0; bus.wr_done = 1'b0;
        bus.rd_busy = 1'b0; bus.rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && (bus.wr_req || bus.rd_req)) begin
                is_wr = bus.wr_req;
                a     = is_wr ? bus.wr_req_addr : bus.rd_req_addr;
                len   = is_wr ? bus.wr_length : bus.rd_length;
                if (len != 16'd64) len_err++;
                if (is_wr) begin
                    bus.wr_busy = 1'b1;
                    wr_seen++;
                end else begin
                    bus.rd_busy = 1'b1;
                end
                @(negedge clk);
                bus.wr_busy = 1'b0;
                bus.rd_busy = 1'b0;
                if (is_wr && wr_seen == abort_at) wr_fs_resp = 1'b1;
                @(negedge clk);
                wr_fs_resp = 1'b0;
                @(negedge clk);
                if (is_wr) bus.wr_done = 1'b1; else bus.rd_done = 1'b1;
                if (is_wr && wr_seen == swap_at) rd_fs_resp = 1'b1;
                if (log_n < 128) begin
                    log_wr[log_n]   = is_wr;
                    log_addr[log_n] = a;
                end
                log_n++;
                @(negedge clk);
                bus.wr_done = 1'b0;
                bus.rd_done = 1'b0;
                rd_fs_resp  = 1'b0;
            end
        end
    end

    int overlap = 0;
    int idx_clash = 0;
    always @(negedge clk) begin
        if (bus.wr_req && bus.rd_req) overlap <= overlap + 1;
        if (!rst && frame_valid && (w_idx == r_idx)) idx_clash <= idx_clash + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        resp_en = 1'b0;
        wr_fifo_cnt = 16'd0;
        rd_fifo_space = 16'd0;
        wr_fs_main = 1'b0;
        rd_fs_main = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_wr();
        wr_fs_main = 1'b1;
        @(negedge clk);
        wr_fs_main = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_fs_main = 1'b1;
        @(negedge clk);
        rd_fs_main = 1'b0;
    endtask

    task automatic wait_log(input int n, input string nm);
        int c = 0;
        while (log_n < n && c < 400) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        chk(nm, 32'(log_n >= n), 32'd1);
    endtask

    typedef struct {
        logic [15:0] wr_cnt;
        logic [15:0] rd_space;
        bit          exp_wr;
        bit          exp_rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int s;
        vecs[0] = '{16'd63,  16'd63,    1'b0, 1'b0};
        vecs[1] = '{16'd64,  16'd63,    1'b1, 1'b0};
        vecs[2] = '{16'd63,  16'd64,    1'b0, 1'b1};
        vecs[3] = '{16'd64,  16'd64,    1'b1, 1'b0};
        vecs[4] = '{16'd0,   16'd65535, 1'b0, 1'b1};
        vecs[5] = '{16'd100, 16'd0,     1'b1, 1'b0};

        // reset state
        do_reset();
        chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
        chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_req_addr), 32'd0);
        chk("rst_wr_len", 32'(bus.wr_length), 32'd0);
        chk("rst_rd_len", 32'(bus.rd_length), 32'd0);
        chk("rst_w_idx", 32'(w_idx), 32'd0);
        chk("rst_r_idx", 32'(r_idx), 32'd2);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // eligibility thresholds, responder disabled so requests stay held
        for (int i = 0; i < 6; i++) begin
            do_reset();
            wr_fifo_cnt   = vecs[i].wr_cnt;
            rd_fifo_space = vecs[i].rd_space;
            wr_fs_main = 1'b1;
            rd_fs_main = 1'b1;
            @(negedge clk);
            wr_fs_main = 1'b0;
            rd_fs_main = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_wr_req", i), 32'(bus.wr_req), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_rd_req", i), 32'(bus.rd_req), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_wr_len", i), 32'(bus.wr_length), vecs[i].exp_wr ? 32'd64 : 32'd0);
            chk($sformatf("vec%0d_rd_addr", i), 32'(bus.rd_req_addr), 32'd0);
        end

        // rd_fifo_space 63 blocks reads; 64 raises rd_req on the next edge
        do_reset();
        rd_fifo_space = 16'd63;
        pulse_rd();
        repeat (5) @(negedge clk);
        chk("rd63_no_req", 32'(bus.rd_req), 32'd0);
        rd_fifo_space = 16'd64;
        @(negedge clk);
        chk("rd64_req", 32'(bus.rd_req), 32'd1);

        // write-only frame, then two more frames with no reader switch
        do_reset();
        resp_en = 1'b1;
        wr_fifo_cnt = 16'd64;
        s = log_n;
        pulse_wr();
        wait_log(s + 4, "frame1_timeout");
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("f1_dir%0d", k), 32'(log_wr[s+k]), 32'd1);
            chk($sformatf("f1_addr%0d", k), 32'(log_addr[s+k]), 32'(k * 512));
        end
        chk("f1_valid", 32'(frame_valid), 32'd1);
        chk("f1_w_idx", 32'(w_idx), 32'd1);
        chk("f1_r_idx", 32'(r_idx), 32'd2);
        chk("f1_drop", 32'(drop_cnt), 32'd0);
        pulse_wr();
        wait_log(s + 8, "frame2_timeout");
        chk("f2_addr0", 32'(log_addr[s+4]), 32'd2048);
        chk("f2_w_idx", 32'(w_idx), 32'd0);
        chk("f2_drop", 32'(drop_cnt), 32'd1);
        pulse_wr();
        wait_log(s + 12, "frame3_timeout");
        chk("f3_addr0", 32'(log_addr[s+8]), 32'd0);
        chk("f3_drop", 32'(drop_cnt), 32'd2);
        chk("f3_w_idx", 32'(w_idx), 32'd1);
        chk("f3_r_idx", 32'(r_idx), 32'd2);
        chk("idx_clash", 32'(idx_clash), 32'd0);
        pulse_rd();
        @(negedge clk);
        chk("sw_r_idx_latest", 32'(r_idx), 32'd0);

        // reader switch in the same cycle as the final wr_done of frame 2
        do_reset();
        resp_en = 1'b1;
        wr_fifo_cnt = 16'd64;
        s = log_n;
        swap_at = wr_seen + 8;
        pulse_wr();
        wait_log(s + 4, "swap_f1_timeout");
        pulse_wr();
        wait_log(s + 8, "swap_f2_timeout");
        chk("swap_r_idx", 32'(r_idx), 32'd1);
        chk("swap_w_idx", 32'(w_idx), 32'd0);
        chk("swap_drop", 32'(drop_cnt), 32'd1);
        pulse_wr();
        wait_log(s + 12, "swap_f3_timeout");
        chk("swap_f3_addr0", 32'(log_addr[s+8]), 32'd0);
        chk("swap_f3_drop", 32'(drop_cnt), 32'd1);
        chk("swap_f3_w_idx", 32'(w_idx), 32'd2);
        swap_at = -1;

        // frame restart during WR_WAIT of burst 2
        do_reset();
        resp_en = 1'b1;
        wr_fifo_cnt = 16'd64;
        s = log_n;
        abort_at = wr_seen + 3;
        pulse_wr();
        wait_log(s + 4, "abort_timeout");
        chk("abort_addr2", 32'(log_addr[s+2]), 32'd1024);
        chk("abort_restart_addr", 32'(log_addr[s+3]), 32'd0);
        chk("abort_valid", 32'(frame_valid), 32'd0);
        chk("abort_w_idx", 32'(w_idx), 32'd0);
        wait_log(s + 7, "abort_finish_timeout");
        chk("abort_last_addr", 32'(log_addr[s+6]), 32'd1536);
        chk("abort_pub_valid", 32'(frame_valid), 32'd1);
        chk("abort_pub_w_idx", 32'(w_idx), 32'd1);
        abort_at = -1;

        // both paths eligible: strict alternation starting with write
        do_reset();
        resp_en = 1'b1;
        wr_fifo_cnt = 16'd64;
        rd_fifo_space = 16'd64;
        s = log_n;
        wr_fs_main = 1'b1;
        rd_fs_main = 1'b1;
        @(negedge clk);
        wr_fs_main = 1'b0;
        rd_fs_main = 1'b0;
        wait_log(s + 6, "alt_timeout");
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("alt_dir%0d", k), 32'(log_wr[s+k]), 32'((k % 2) == 0));
            chk($sformatf("alt_addr%0d", k), 32'(log_addr[s+k]), 32'((k / 2) * 512));
        end
        resp_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("req_overlap", 32'(overlap), 32'd0);
        chk("length_errors", 32'(len_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
